// File: rtl/cpu_pkg.sv
// Shared types and constants for the accumulator CPU sequencer.
package cpu_pkg;

  localparam int OPC_W   = 5;
  localparam int ADDR_W  = 11;
  localparam int INSTR_W = 16;
  localparam int ALU_N   = 18;

  // Opcodes outside the ALU range. Opcodes 0..17 are ALU functions.
  localparam logic [OPC_W-1:0] OP_LDA = 5'b10010;
  localparam logic [OPC_W-1:0] OP_STA = 5'b10011;
  localparam logic [OPC_W-1:0] OP_JMP = 5'b10100;
  localparam logic [OPC_W-1:0] OP_JZ  = 5'b10101;
  localparam logic [OPC_W-1:0] OP_JN  = 5'b10110;
  localparam logic [OPC_W-1:0] OP_HLT = 5'b10111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    CLS_ALU = 3'd0,
    CLS_LDA = 3'd1,
    CLS_STA = 3'd2,
    CLS_JMP = 3'd3,
    CLS_JZ  = 3'd4,
    CLS_JN  = 3'd5,
    CLS_HLT = 3'd6,
    CLS_ILL = 3'd7
  } op_class_e;

  // {zx,nx,zy,ny,f,no} per ALU opcode; D = accumulator side, A = operand side.
  localparam logic [5:0] ALU_CTRL [ALU_N] = '{
    6'b101010,  // 00: 0
    6'b111111,  // 01: 1
    6'b111010,  // 02: -1
    6'b001100,  // 03: D
    6'b110000,  // 04: A
    6'b001101,  // 05: !D
    6'b110001,  // 06: !A
    6'b001111,  // 07: -D
    6'b110011,  // 08: -A
    6'b011111,  // 09: D+1
    6'b110111,  // 10: A+1
    6'b001110,  // 11: D-1
    6'b110010,  // 12: A-1
    6'b000010,  // 13: D+A
    6'b010011,  // 14: D-A
    6'b000111,  // 15: A-D
    6'b000000,  // 16: D&A
    6'b010101   // 17: D|A
  };

endpackage

// File: rtl/cpu_sequencer_if.sv
// Instruction fetch handshake between the sequencer and instruction memory.
interface cpu_sequencer_if;
  import cpu_pkg::*;

  logic               instr_req;
  logic               instr_valid;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  pc;

  modport master (output instr_req, output pc, input instr_valid, input instr);
  modport slave  (input instr_req, input pc, output instr_valid, output instr);
endinterface

// File: rtl/cpu_sequencer_instr_decoder.sv
// Combinational opcode decode: instruction class and ALU function lines.
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [OPC_W-1:0] opc,
  output op_class_e        cls,
  output logic [5:0]       alu_ctrl
);

  // Map opcode to class; ALU lines only meaningful for the ALU class.
  always_comb begin
    cls      = CLS_ILL;
    alu_ctrl = '0;
    if (opc < OPC_W'(ALU_N)) begin
      cls      = CLS_ALU;
      alu_ctrl = ALU_CTRL[opc];
    end else begin
      case (opc)
        OP_LDA:  cls = CLS_LDA;
        OP_STA:  cls = CLS_STA;
        OP_JMP:  cls = CLS_JMP;
        OP_JZ:   cls = CLS_JZ;
        OP_JN:   cls = CLS_JN;
        OP_HLT:  cls = CLS_HLT;
        default: cls = CLS_ILL;
      endcase
    end
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Fetch/execute sequencer: FSM, instruction register and program counter.
module cpu_sequencer
  import cpu_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  cpu_sequencer_if.master     fetch,
  input  logic                zr,
  input  logic                ng,
  output logic [5:0]          alu_ctrl,
  output logic                acc_load,
  output logic                acc_src,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                halted,
  output logic                illegal
);

  state_e             state, state_d;
  logic [INSTR_W-1:0] ir, ir_d;
  logic [ADDR_W-1:0]  pc, pc_d;
  logic               req;
  logic               take;
  op_class_e          cls;
  logic [5:0]         dec_alu;

  instr_decoder u_dec (
    .opc      (ir[INSTR_W-1:INSTR_W-OPC_W]),
    .cls      (cls),
    .alu_ctrl (dec_alu)
  );

  assign fetch.instr_req = req;
  assign fetch.pc        = pc;
  assign mem_addr        = ir[ADDR_W-1:0];
  assign acc_src         = (cls == CLS_LDA);

  // State, IR and PC registers; reset abandons any fetch in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      ir    <= '0;
      pc    <= '0;
    end else begin
      state <= state_d;
      ir    <= ir_d;
      pc    <= pc_d;
    end
  end

  // Next state and control strobes; all strobes live only in EXEC.
  always_comb begin
    state_d  = state;
    ir_d     = ir;
    pc_d     = pc;
    req      = 1'b0;
    take     = 1'b0;
    alu_ctrl = '0;
    acc_load = 1'b0;
    mem_we   = 1'b0;
    illegal  = 1'b0;
    halted   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (run) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        req = 1'b1;
        if (fetch.instr_valid) begin
          ir_d    = fetch.instr;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (cls)
          CLS_ALU: begin
            alu_ctrl = dec_alu;
            acc_load = 1'b1;
          end
          CLS_LDA: acc_load = 1'b1;
          CLS_STA: mem_we   = 1'b1;
          CLS_JMP: take     = 1'b1;
          CLS_JZ:  take     = zr;
          CLS_JN:  take     = ng;
          CLS_HLT: ;
          default: illegal  = 1'b1;
        endcase
        if (cls == CLS_HLT) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_FETCH;
          pc_d    = take ? ir[ADDR_W-1:0] : pc + ADDR_W'(1);
        end
      end
      default: begin
        halted = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer; inputs change and outputs are sampled on negedge.
module tb_cpu_sequencer;
  import cpu_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n, run, zr, ng;
  logic [5:0]        alu_ctrl;
  logic              acc_load, acc_src, mem_we, halted, illegal;
  logic [ADDR_W-1:0] mem_addr;
  int                n_vec = 0;
  int                n_err = 0;
  int                cnt;

  cpu_sequencer_if bus ();

  cpu_sequencer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (run),
    .fetch    (bus),
    .zr       (zr),
    .ng       (ng),
    .alu_ctrl (alu_ctrl),
    .acc_load (acc_load),
    .acc_src  (acc_src),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .halted   (halted),
    .illegal  (illegal)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Fetch one instruction that is valid in the first FETCH cycle; ends in EXEC.
  task automatic issue(input logic [INSTR_W-1:0] w);
    bus.instr_valid = 1'b1;
    bus.instr       = w;
    tick();
    bus.instr_valid = 1'b0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_req"},  32'(bus.instr_req), 32'd0);
    chk({tag, "_pc"},   32'(bus.pc), 32'd0);
    chk({tag, "_strb"}, {29'd0, acc_load, mem_we, illegal}, 32'd0);
    chk({tag, "_alu"},  32'(alu_ctrl), 32'd0);
    chk({tag, "_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_misc"}, {30'd0, acc_src, halted}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; zr = 1'b0; ng = 1'b0;
    bus.instr_valid = 1'b0; bus.instr = '0;
    @(negedge clk);
    tick();
    chk_quiet("rst");

    // instr 0x0000 with valid tied high: FETCH cycle 2, EXEC cycle 3, pc=1 cycle 4
    rst_n = 1'b1; run = 1'b1; bus.instr_valid = 1'b1; bus.instr = 16'h0000;
    tick();
    chk("c2_req", 32'(bus.instr_req), 32'd1);
    tick();
    chk("c3_alu", 32'(alu_ctrl), 32'h2A);
    chk("c3_load", {30'd0, acc_load, acc_src}, 32'b10);
    run = 1'b0; bus.instr_valid = 1'b0;
    tick();
    chk("c4_pc", 32'(bus.pc), 32'd1);
    chk("c4_load", 32'(acc_load), 32'd0);

    // add with valid delayed by three cycles
    cnt = 0;
    bus.instr = 16'h6800;
    for (int i = 0; i < 4; i++) begin
      if (bus.instr_req) cnt++;
      bus.instr_valid = (i == 3);
      tick();
    end
    bus.instr_valid = 1'b0;
    chk("wait_req", 32'(cnt), 32'd4);
    chk("add_alu", 32'(alu_ctrl), 32'h02);
    chk("add_load", 32'(acc_load), 32'd1);
    tick();
    chk("add_once", 32'(acc_load), 32'd0);
    chk("add_pc", 32'(bus.pc), 32'd2);

    // conditional jumps with zr=1
    zr = 1'b1; ng = 1'b0;
    issue(16'hA923);
    tick();
    chk("jz_pc", 32'(bus.pc), 32'h123);
    issue(16'hB123);
    tick();
    chk("jn_pc", 32'(bus.pc), 32'h124);
    zr = 1'b0;

    // LDA selects memory data
    issue(16'h9010);
    chk("lda_strb", {29'd0, acc_load, acc_src, mem_we}, 32'b110);
    chk("lda_addr", 32'(mem_addr), 32'h010);
    tick();
    chk("lda_pc", 32'(bus.pc), 32'h125);

    // STA at pc 2047, pc wraps
    issue(16'hA7FF);
    tick();
    chk("jmp_pc", 32'(bus.pc), 32'h7FF);
    issue(16'h9FFF);
    chk("sta_strb", {30'd0, acc_load, mem_we}, 32'b01);
    chk("sta_addr", 32'(mem_addr), 32'h7FF);
    tick();
    chk("sta_once", 32'(mem_we), 32'd0);
    chk("wrap_pc", 32'(bus.pc), 32'd0);

    // undefined opcode then HLT
    issue(16'hD000);
    chk("ill_strb", {29'd0, illegal, acc_load, mem_we}, 32'b100);
    chk("ill_alu", 32'(alu_ctrl), 32'd0);
    tick();
    chk("ill_once", 32'(illegal), 32'd0);
    chk("ill_pc", 32'(bus.pc), 32'd1);
    issue(16'hB800);
    chk("hlt_exec", 32'(halted), 32'd0);
    tick();
    chk("halted", 32'(halted), 32'd1);
    run = 1'b1; bus.instr_valid = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.instr_req || acc_load || mem_we || illegal || !halted) cnt++;
      tick();
    end
    chk("halt_quiet", 32'(cnt), 32'd0);
    chk("halt_pc", 32'(bus.pc), 32'd1);

    // reset during FETCH with valid high at the same edge
    rst_n = 1'b0; run = 1'b0; bus.instr_valid = 1'b0;
    tick();
    rst_n = 1'b1; run = 1'b1;
    tick();
    run = 1'b0;
    issue(16'hA055);
    tick();
    chk("pre_pc", 32'(bus.pc), 32'h055);
    chk("pre_req", 32'(bus.instr_req), 32'd1);
    rst_n = 1'b0; bus.instr_valid = 1'b1; bus.instr = 16'h9FFF;
    tick();
    chk_quiet("mid_rst");
    rst_n = 1'b1;
    tick();
    chk_quiet("idle");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
